// File: rtl/alg_amba_vip_base_delay_gen.sv
// Responder-side latency injector: each accepted request gets a policy-driven delay
// and is acknowledged in order once it elapses. Optional: ALG_AMBA_VIP_DELAY_GEN_SEQ_ID_EN.
module alg_amba_vip_base_delay_gen #(
  parameter int unsigned TIMER_WIDTH          = 16,
  parameter int unsigned OUTSTANDING_LOG2_MAX = 6,
  parameter logic [15:0] LFSR_SEED            = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          cnt_rst,
  input  logic [1:0]                    cfg_mode,
  input  logic [TIMER_WIDTH-1:0]        cfg_min_delay,
  input  logic [TIMER_WIDTH-1:0]        cfg_max_delay,
  input  logic                          req_valid,
  output logic                          ack_valid,
  input  logic                          ack_ready,
  output logic [OUTSTANDING_LOG2_MAX:0] outstanding,
  output logic                          busy,
  output logic                          err_fifo_full,
`ifdef ALG_AMBA_VIP_DELAY_GEN_SEQ_ID_EN
  output logic [15:0]                   req_seq_id,
  output logic [15:0]                   ack_seq_id,
`endif
  output logic                          err_cfg
);

  localparam int unsigned TW    = TIMER_WIDTH;
  localparam int unsigned AW    = TIMER_WIDTH + 1;
  localparam int unsigned PW    = OUTSTANDING_LOG2_MAX;
  localparam int unsigned CW    = OUTSTANDING_LOG2_MAX + 1;
  localparam int unsigned DEPTH = 1 << OUTSTANDING_LOG2_MAX;

  typedef struct packed {
`ifdef ALG_AMBA_VIP_DELAY_GEN_SEQ_ID_EN
    logic [15:0]   id;
`endif
    logic [TW-1:0] ts;
    logic [TW-1:0] dly;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [TW-1:0] sweep_q, sweep_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          err_fifo_full_q, err_fifo_full_d;
  logic          err_cfg_q, err_cfg_d;
`ifdef ALG_AMBA_VIP_DELAY_GEN_SEQ_ID_EN
  logic [15:0]   seq_q, seq_d;
`endif

  entry_t        head_c, wr_entry_c;
  logic [TW-1:0] elapsed_c, dly_c;
  logic [AW-1:0] min_w_c, max_w_c, range_w_c, dly_w_c;
  logic          ack_valid_c, pop_c, push_c, drop_c, full_c, req_live_c, cfg_bad_c;

  // Head readiness uses modular elapsed time so the timer may wrap freely.
  always_comb begin
    head_c      = mem_q[rd_ptr_q];
    elapsed_c   = timer_q - head_c.ts;
    ack_valid_c = (cnt_q != '0) && (elapsed_c >= head_c.dly);
    pop_c       = ack_valid_c && ack_ready;
    full_c      = (cnt_q == CW'(DEPTH));
    req_live_c  = req_valid && !cnt_rst;
    push_c      = req_live_c && (!full_c || pop_c);
    drop_c      = req_live_c && full_c && !pop_c;
  end

  // Delay policy for the request presented this cycle.
  always_comb begin
    min_w_c   = AW'(cfg_min_delay);
    max_w_c   = AW'(cfg_max_delay);
    range_w_c = max_w_c - min_w_c + AW'(1);
    cfg_bad_c = (cfg_mode == 2'd3) ||
                ((cfg_mode == 2'd1 || cfg_mode == 2'd2) && (cfg_min_delay > cfg_max_delay));
    dly_w_c   = min_w_c;
    if (!cfg_bad_c) begin
      case (cfg_mode)
        2'd1:    dly_w_c = min_w_c + (AW'(lfsr_q) % range_w_c);
        2'd2:    dly_w_c = min_w_c + AW'(sweep_q);
        default: dly_w_c = min_w_c;
      endcase
    end
    if (dly_w_c == '0) dly_c = TW'(1);
    else               dly_c = TW'(dly_w_c);
    wr_entry_c     = '0;
    wr_entry_c.ts  = timer_q;
    wr_entry_c.dly = dly_c;
`ifdef ALG_AMBA_VIP_DELAY_GEN_SEQ_ID_EN
    wr_entry_c.id  = seq_q;
`endif
  end

  always_comb begin
    timer_d         = timer_q + TW'(1);
    lfsr_d          = lfsr_q;
    sweep_d         = sweep_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    cnt_d           = cnt_q;
    err_fifo_full_d = err_fifo_full_q;
    err_cfg_d       = err_cfg_q;
`ifdef ALG_AMBA_VIP_DELAY_GEN_SEQ_ID_EN
    seq_d           = seq_q;
`endif
    if (cnt_rst) begin
      sweep_d         = '0;
      rd_ptr_d        = '0;
      wr_ptr_d        = '0;
      cnt_d           = '0;
      err_fifo_full_d = 1'b0;
      err_cfg_d       = 1'b0;
`ifdef ALG_AMBA_VIP_DELAY_GEN_SEQ_ID_EN
      seq_d           = '0;
`endif
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = cnt_q + CW'(push_c) - CW'(pop_c);
      if (push_c && !cfg_bad_c && cfg_mode == 2'd1)
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      if (push_c && !cfg_bad_c && cfg_mode == 2'd2) begin
        if ((min_w_c + AW'(sweep_q)) >= max_w_c) sweep_d = '0;
        else                                     sweep_d = sweep_q + TW'(1);
      end
      if (drop_c)                  err_fifo_full_d = 1'b1;
      if (req_live_c && cfg_bad_c) err_cfg_d       = 1'b1;
`ifdef ALG_AMBA_VIP_DELAY_GEN_SEQ_ID_EN
      if (push_c) seq_d = seq_q + 16'd1;
`endif
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      timer_q         <= '0;
      lfsr_q          <= LFSR_SEED;
      sweep_q         <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      cnt_q           <= '0;
      busy_q          <= 1'b0;
      err_fifo_full_q <= 1'b0;
      err_cfg_q       <= 1'b0;
`ifdef ALG_AMBA_VIP_DELAY_GEN_SEQ_ID_EN
      seq_q           <= '0;
`endif
    end else begin
      timer_q         <= timer_d;
      lfsr_q          <= lfsr_d;
      sweep_q         <= sweep_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      cnt_q           <= cnt_d;
      busy_q          <= busy_d;
      err_fifo_full_q <= err_fifo_full_d;
      err_cfg_q       <= err_cfg_d;
`ifdef ALG_AMBA_VIP_DELAY_GEN_SEQ_ID_EN
      seq_q           <= seq_d;
`endif
    end
  end

  // Entry storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= wr_entry_c;
  end

  assign ack_valid     = ack_valid_c;
  assign outstanding   = cnt_q;
  assign busy          = busy_q;
  assign err_fifo_full = err_fifo_full_q;
  assign err_cfg       = err_cfg_q;
`ifdef ALG_AMBA_VIP_DELAY_GEN_SEQ_ID_EN
  assign req_seq_id    = seq_q;
  assign ack_seq_id    = head_c.id;
`endif

endmodule
